d_cache_ctrl: RTL and testbench
===============================

// Module: d_cache_ctrl
// PURPOSE
//  Initiator side of the cc_* lookup interface. Sits between the CPU load/store port, the d_cache arrays and main memory.
//  Sequences lookup, read-miss refill and write-through. The CPU sees a single req/ack handshake.
// PARAMETERS
//  ADR_LENGTH   32  address width, all ports
//  DATA_LENGTH  32  data word width, all ports
//  CNT_WIDTH    16  statistics counter width (DCC_STATS_EN only)
// PORTS
//  clk_i        in   1            single clock, all state changes on rising edge
//  rst_ni       in   1            asynchronous active-low reset
//  cpu_req_i    in   1            access request, level, sampled in IDLE only
//  cpu_we_i     in   1            1=store, 0=load
//  cpu_adr_i    in   ADR_LENGTH   access address
//  cpu_dat_i    in   DATA_LENGTH  store data
//  cpu_ack_o    out  1            one-cycle completion pulse
//  cpu_dat_o    out  DATA_LENGTH  load data, held until next load completes
//  cc_req_o     out  1            cache access strobe
//  cc_adr_o     out  ADR_LENGTH   cache address
//  cc_dat_o     out  DATA_LENGTH  cache write data
//  cc_we_o      out  1            cache array write enable
//  cc_hit_i     in   1            cache hit, combinational, same cycle as cc_req_o
//  cc_valid_i   in   1            cache result valid, same cycle
//  cc_dat_i     in   DATA_LENGTH  cache read data
//  mem_req_o    out  1            memory request, level, held until mem_ack_i
//  mem_we_o     out  1            memory write
//  mem_adr_o    out  ADR_LENGTH   memory address
//  mem_dat_o    out  DATA_LENGTH  memory write data
//  mem_ack_i    in   1            memory done, one-cycle pulse
//  mem_dat_i    in   DATA_LENGTH  memory read data, valid with mem_ack_i
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE. Async assertion drops mem_req_o/cc_req_o immediately. An in-flight access is abandoned; no ack is issued.
//  Request latch: cpu_adr/dat/we are latched on the edge where IDLE samples cpu_req_i=1. Later CPU input changes are ignored.
//  FSM states: IDLE, LOOKUP, MEM_RD, FILL, MEM_WR, CC_UPD, RESP.
//  IDLE -> LOOKUP when cpu_req_i=1.
//  LOOKUP, 1 cycle: cc_req_o=1, cc_we_o=0, cc_adr_o=latched adr.
//    hit = cc_hit_i & cc_valid_i, registered as hit_q.
//    load hit: cpu_dat_o<=cc_dat_i, go RESP.
//    load miss: go MEM_RD.
//    store: go MEM_WR.
//  MEM_RD: mem_req_o=1, mem_we_o=0, adr stable until mem_ack_i.
//    On ack: capture mem_dat_i into the cpu_dat_o register, go FILL.
//  FILL, 1 cycle: cc_req_o=1, cc_we_o=1, cc_dat_o=refilled word, go RESP.
//  MEM_WR: mem_req_o=1, mem_we_o=1, mem_dat_o=store data.
//    On ack: go CC_UPD if hit_q, else RESP (no-write-allocate).
//  CC_UPD, 1 cycle: cc_req_o=1, cc_we_o=1, cc_dat_o=store data, go RESP.
//  RESP, 1 cycle: cpu_ack_o=1, go IDLE.
//    cpu_req_i still high in IDLE is a new access; CPU drops req on ack.
//  Latency counted from the sampling edge (edge 0):
//    load hit: ack high in cycle after edge 2.
//    load miss: edge 2 + memory wait + 2.
//    store: edge 2 + memory wait + 1, or +2 when hit_q.
//  mem_ack_i outside MEM_RD/MEM_WR is ignored.
//  Ack in the first MEM cycle is legal, giving zero memory wait.
//  mem_req_o deasserts the cycle after ack.
//  cc_hit_i/cc_valid_i are ignored outside LOOKUP.
//  Interpretation fixed in the controller: cc_hit_i=1 with cc_valid_i=0 is a miss.
// CONFIGURATION
//  DCC_STATS_EN defined: adds ports hit_cnt_o and miss_cnt_o, out, CNT_WIDTH each.
//    One count per LOOKUP cycle, loads and stores.
//    Counters saturate at all-ones and reset to 0.
//  DCC_STATS_EN undefined: ports and counter logic absent. All other behaviour is identical.
// TESTING
//  1 Reset: rst_ni=0 mid MEM_RD -> mem_req_o=0 at once; after release no cpu_ack_o, FSM IDLE.
//  2 Load hit: req adr=0x0000_0040, cc_hit_i=cc_valid_i=1, cc_dat_i=0xDEADBEEF
//      -> ack 2 cycles after sampling edge, cpu_dat_o=0xDEADBEEF, mem_req_o never 1.
//  3 Load miss: adr=0x0000_1000, hit=0, mem_ack_i after 3 cycles with 0x12345678
//      -> one FILL cycle with cc_we_o=1, cc_dat_o=0x12345678; then ack, cpu_dat_o=0x12345678.
//  4 Store hit: adr=0x80, dat=0xA5A5A5A5, hit=1
//      -> MEM_WR with mem_we_o=1, mem_dat_o=0xA5A5A5A5; CC_UPD writes cache; then ack.
//  5 Store miss: hit=0 -> memory write only, cc_we_o never 1, then ack.
//    Zero-wait mem_ack_i gives ack 2 cycles after MEM_WR entry.
//  6 DCC_STATS_EN with CNT_WIDTH=2: 5 hits -> hit_cnt_o=3 (saturated).
//    Stray mem_ack_i in IDLE has no effect.

Source files
------------

// File: rtl/d_cache_ctrl.sv
// rtl/d_cache_ctrl.sv - data cache controller: lookup, read-miss refill, write-through
// Optional hit/miss statistics counters are built when DCC_STATS_EN is defined.
module d_cache_ctrl #(
   parameter int ADR_LENGTH  = 32,
   parameter int DATA_LENGTH = 32,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   cpu_req_i,
   input  logic                   cpu_we_i,
   input  logic [ADR_LENGTH-1:0]  cpu_adr_i,
   input  logic [DATA_LENGTH-1:0] cpu_dat_i,
   output logic                   cpu_ack_o,
   output logic [DATA_LENGTH-1:0] cpu_dat_o,
   output logic                   cc_req_o,
   output logic [ADR_LENGTH-1:0]  cc_adr_o,
   output logic [DATA_LENGTH-1:0] cc_dat_o,
   output logic                   cc_we_o,
   input  logic                   cc_hit_i,
   input  logic                   cc_valid_i,
   input  logic [DATA_LENGTH-1:0] cc_dat_i,
   output logic                   mem_req_o,
   output logic                   mem_we_o,
   output logic [ADR_LENGTH-1:0]  mem_adr_o,
   output logic [DATA_LENGTH-1:0] mem_dat_o,
   input  logic                   mem_ack_i,
   input  logic [DATA_LENGTH-1:0] mem_dat_i
`ifdef DCC_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0]   hit_cnt_o,
   output logic [CNT_WIDTH-1:0]   miss_cnt_o
`endif
);

   typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, FILL, MEM_WR, CC_UPD, RESP} state_t;

   state_t                 state_q, state_d;
   logic [ADR_LENGTH-1:0]  adr_q, adr_d;
   logic [DATA_LENGTH-1:0] dat_q, dat_d;
   logic [DATA_LENGTH-1:0] rdat_q, rdat_d;
   logic                   we_q, we_d;
   logic                   hit_q, hit_d;
   logic                   ack_q, ack_d;
   logic                   hit;

   // A hit flagged without valid data is treated as a miss.
   assign hit = cc_hit_i & cc_valid_i;

   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      rdat_d  = rdat_q;
      we_d    = we_q;
      hit_d   = hit_q;
      ack_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu_req_i) begin
               adr_d   = cpu_adr_i;
               dat_d   = cpu_dat_i;
               we_d    = cpu_we_i;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            hit_d = hit;
            if (we_q) begin
               state_d = MEM_WR;
            end else if (hit) begin
               rdat_d  = cc_dat_i;
               state_d = RESP;
            end else begin
               state_d = MEM_RD;
            end
         end
         MEM_RD: begin
            if (mem_ack_i) begin
               rdat_d  = mem_dat_i;
               state_d = FILL;
            end
         end
         FILL:   state_d = RESP;
         MEM_WR: begin
            if (mem_ack_i) state_d = hit_q ? CC_UPD : RESP;
         end
         CC_UPD: state_d = RESP;
         RESP: begin
            ack_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         adr_q   <= '0;
         dat_q   <= '0;
         rdat_q  <= '0;
         we_q    <= 1'b0;
         hit_q   <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         rdat_q  <= rdat_d;
         we_q    <= we_d;
         hit_q   <= hit_d;
         ack_q   <= ack_d;
      end
   end

   // Strobes decode straight from state so an async reset drops them at once.
   assign cpu_ack_o = ack_q;
   assign cpu_dat_o = rdat_q;
   assign cc_req_o  = (state_q == LOOKUP) || (state_q == FILL) || (state_q == CC_UPD);
   assign cc_we_o   = (state_q == FILL) || (state_q == CC_UPD);
   assign cc_adr_o  = adr_q;
   assign cc_dat_o  = (state_q == FILL)   ? rdat_q :
                      (state_q == CC_UPD) ? dat_q  : '0;
   assign mem_req_o = (state_q == MEM_RD) || (state_q == MEM_WR);
   assign mem_we_o  = (state_q == MEM_WR);
   assign mem_adr_o = adr_q;
   assign mem_dat_o = dat_q;

`ifdef DCC_STATS_EN
   logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
   logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (state_q == LOOKUP) begin
         if (hit && (hit_cnt_q != '1))        hit_cnt_d  = hit_cnt_q + 1'b1;
         else if (!hit && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_d_cache_ctrl.sv
// tb/tb_d_cache_ctrl.sv - scoreboard bench for d_cache_ctrl
// Stats checks are built when DCC_STATS_EN is defined.
module tb_d_cache_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        cpu_req_i = 1'b0;
   logic        cpu_we_i = 1'b0;
   logic [31:0] cpu_adr_i = '0;
   logic [31:0] cpu_dat_i = '0;
   logic        cpu_ack_o;
   logic [31:0] cpu_dat_o;
   logic        cc_req_o;
   logic [31:0] cc_adr_o;
   logic [31:0] cc_dat_o;
   logic        cc_we_o;
   logic        cc_hit_i = 1'b0;
   logic        cc_valid_i = 1'b0;
   logic [31:0] cc_dat_i = '0;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_adr_o;
   logic [31:0] mem_dat_o;
   logic        mem_ack_i;
   logic [31:0] mem_dat_i = '0;
`ifdef DCC_STATS_EN
   logic [1:0]  hit_cnt_o;
   logic [1:0]  miss_cnt_o;
`endif

   logic        mem_ack_r = 1'b0;
   logic        stray_ack = 1'b0;
   assign mem_ack_i = mem_ack_r | stray_ack;

   d_cache_ctrl #(.ADR_LENGTH(32), .DATA_LENGTH(32), .CNT_WIDTH(2)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i),
      .cpu_ack_o(cpu_ack_o), .cpu_dat_o(cpu_dat_o),
      .cc_req_o(cc_req_o), .cc_adr_o(cc_adr_o), .cc_dat_o(cc_dat_o), .cc_we_o(cc_we_o),
      .cc_hit_i(cc_hit_i), .cc_valid_i(cc_valid_i), .cc_dat_i(cc_dat_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o),
      .mem_ack_i(mem_ack_i), .mem_dat_i(mem_dat_i)
`ifdef DCC_STATS_EN
      , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] dat;
      int          cyc;
   } exp_t;

   exp_t        sb_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          mem_wait = 0;
   int          wcnt = 0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] last_load = '0;
   int          n_memreq = 0;
   int          n_ccwe = 0;
   logic [31:0] ccwe_dat = '0;
   logic [31:0] lk_adr = '0;
   logic        wr_we = 1'b0;
   logic [31:0] wr_adr = '0;
   logic [31:0] wr_dat = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(posedge clk_i) cyc <= cyc + 1;

   // Memory model: acks after mem_wait cycles of mem_req_o, records the request.
   always @(negedge clk_i) begin
      mem_ack_r = 1'b0;
      if (mem_req_o) begin
         if (wcnt == mem_wait) begin
            mem_ack_r = 1'b1;
            mem_dat_i = mem_rdata;
            wr_we     = mem_we_o;
            wr_adr    = mem_adr_o;
            wr_dat    = mem_dat_o;
            wcnt      = 0;
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
      end
   end

   // Monitor: pops the scoreboard on every cpu_ack_o and tallies bus traffic.
   always @(negedge clk_i) begin
      exp_t e;
      if (mem_req_o) n_memreq++;
      if (cc_req_o && cc_we_o) begin
         n_ccwe++;
         ccwe_dat = cc_dat_o;
      end
      if (cc_req_o && !cc_we_o) lk_adr = cc_adr_o;
      if (cpu_ack_o) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_ack", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("cpu_dat_o", cpu_dat_o, e.dat);
            chk("ack_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic do_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic hit, input logic valid, input logic [31:0] cdat,
                            input int w, input logic [31:0] rdata);
      exp_t e;
      int   lat;
      @(negedge clk_i);
      n_memreq   = 0;
      n_ccwe     = 0;
      mem_wait   = w;
      mem_rdata  = rdata;
      cc_hit_i   = hit;
      cc_valid_i = valid;
      cc_dat_i   = cdat;
      cpu_we_i   = we;
      cpu_adr_i  = adr;
      cpu_dat_i  = dat;
      cpu_req_i  = 1'b1;
      if (!we) lat = (hit && valid) ? 2 : 4 + w;
      else     lat = (hit && valid) ? 4 + w : 3 + w;
      if (!we) last_load = (hit && valid) ? cdat : rdata;
      e.dat = last_load;
      e.cyc = cyc + 1 + lat;
      sb_q.push_back(e);
      @(negedge clk_i);
      cpu_req_i = 1'b0;
      cpu_we_i  = ~we;
      cpu_adr_i = ~adr;
      cpu_dat_i = ~dat;
      repeat (w + 8) @(negedge clk_i);
      chk("ack_seen", sb_q.size(), 32'd0);
      sb_q.delete();
      cc_hit_i   = 1'b0;
      cc_valid_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk_i);
      chk("rst_ack", cpu_ack_o, 32'd0);
      chk("rst_mem_req", mem_req_o, 32'd0);
      chk("rst_cc_req", cc_req_o, 32'd0);
      chk("rst_cpu_dat", cpu_dat_o, 32'd0);
      rst_ni = 1'b1;

      do_access(1'b0, 32'h0000_0040, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF, 0, 32'h0);
      chk("lh_mem_req", n_memreq, 32'd0);
      chk("lh_cc_adr", lk_adr, 32'h0000_0040);

      do_access(1'b0, 32'h0000_1000, 32'h0, 1'b0, 1'b0, 32'hFFFF_0000, 3, 32'h12345678);
      chk("lm_fill_cnt", n_ccwe, 32'd1);
      chk("lm_fill_dat", ccwe_dat, 32'h12345678);
      chk("lm_mem_adr", wr_adr, 32'h0000_1000);
      chk("lm_mem_we", wr_we, 32'd0);

      do_access(1'b1, 32'h0000_0080, 32'hA5A5A5A5, 1'b1, 1'b1, 32'h0, 1, 32'h0);
      chk("sh_mem_we", wr_we, 32'd1);
      chk("sh_mem_dat", wr_dat, 32'hA5A5A5A5);
      chk("sh_upd_cnt", n_ccwe, 32'd1);
      chk("sh_upd_dat", ccwe_dat, 32'hA5A5A5A5);

      do_access(1'b1, 32'h0000_0084, 32'h11223344, 1'b0, 1'b1, 32'h0, 0, 32'h0);
      chk("sm_cc_we_cnt", n_ccwe, 32'd0);
      chk("sm_mem_adr", wr_adr, 32'h0000_0084);
      chk("sm_mem_dat", wr_dat, 32'h11223344);

      // hit without valid must take the miss path
      do_access(1'b0, 32'h0000_0200, 32'h0, 1'b1, 1'b0, 32'hBAD0BAD0, 0, 32'hCAFEF00D);
      chk("hv_fill_cnt", n_ccwe, 32'd1);

      @(negedge clk_i);
      stray_ack = 1'b1;
      @(negedge clk_i);
      stray_ack = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("stray_mem_req", mem_req_o, 32'd0);
      chk("stray_cc_req", cc_req_o, 32'd0);
      chk("stray_cpu_dat", cpu_dat_o, 32'hCAFEF00D);

      @(negedge clk_i);
      mem_wait  = 20;
      cc_hit_i  = 1'b0;
      cpu_we_i  = 1'b0;
      cpu_adr_i = 32'h0000_3000;
      cpu_req_i = 1'b1;
      @(negedge clk_i);
      cpu_req_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("mr_mem_req_before", mem_req_o, 32'd1);
      #1 rst_ni = 1'b0;
      #1;
      chk("mr_mem_req_async", mem_req_o, 32'd0);
      chk("mr_cc_req_async", cc_req_o, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      last_load = '0;
      repeat (6) @(negedge clk_i);
      chk("mr_mem_req_after", mem_req_o, 32'd0);
      chk("mr_cpu_dat", cpu_dat_o, 32'd0);

`ifdef DCC_STATS_EN
      chk("st_hit_rst", hit_cnt_o, 32'd0);
      for (int i = 0; i < 5; i++)
         do_access(1'b0, 32'h100 + 4 * i, 32'h0, 1'b1, 1'b1, 32'h5000_0000 + i, 0, 32'h0);
      chk("st_hit_sat", hit_cnt_o, 32'd3);
      chk("st_miss_zero", miss_cnt_o, 32'd0);
      do_access(1'b1, 32'h0000_0400, 32'h77777777, 1'b0, 1'b0, 32'h0, 0, 32'h0);
      chk("st_miss_one", miss_cnt_o, 32'd1);
      chk("st_hit_hold", hit_cnt_o, 32'd3);
`endif

      repeat (2) @(negedge clk_i);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
